// File: rtl/swt_led_ctrl.sv
// -----------------------------------------------------------------------------
// swt_led_ctrl
//
// Clocked switch-to-LED block for the lab top level. Every raw switch input is
// brought into the clk domain through a 2-FF synchroniser, debounced by a
// per-bit saturating counter, and the debounced vector drives a registered LED
// output in one of these modes:
//   mode 00 / 11 : fixed lab1 logic function of the debounced switches
//   mode 01      : per-bit toggle register, flipped on debounced rising edges
//   mode 10      : blink (debounced switches gated by a slow square wave) when
//                  LED_BLINK_EN is defined, otherwise identical to mode 00
//
// Build option:
//   LED_BLINK_EN  - when defined, adds the free-running blink counter and the
//                   mode 10 blink behaviour. Undefined by default.
//
// Parameters:
//   N_SW       - switch/LED channel count (>= 4)
//   DEB_CYCLES - consecutive differing samples needed to accept a new level (>= 1)
//   BLINK_DIV  - blink half-period in clk cycles (>= 1, LED_BLINK_EN only)
//
// Ports:
//   clk    in   1     system clock, rising edge
//   reset  in   1     asynchronous, active-high reset
//   swt    in   N_SW  raw switch inputs, asynchronous to clk
//   mode   in   2     LED source select, synchronous to clk
//   led    out  N_SW  registered LED drive
//   sw_db  out  N_SW  debounced switch vector
//   chg    out  1     one-cycle pulse after any sw_db bit changed
// -----------------------------------------------------------------------------
module swt_led_ctrl #(
    parameter int N_SW       = 8,
    parameter int DEB_CYCLES = 16,
    parameter int BLINK_DIV  = 4096
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_SW-1:0] swt,
    input  logic [1:0]      mode,
    output logic [N_SW-1:0] led,
    output logic [N_SW-1:0] sw_db,
    output logic            chg
);

    // Elaboration-time parameter sanity checks.
    if (N_SW < 4) begin : g_chk_n_sw
        $error("swt_led_ctrl: N_SW must be >= 4");
    end
    if (DEB_CYCLES < 1) begin : g_chk_deb
        $error("swt_led_ctrl: DEB_CYCLES must be >= 1");
    end
    if (BLINK_DIV < 1) begin : g_chk_blink
        $error("swt_led_ctrl: BLINK_DIV must be >= 1");
    end

    localparam int              CNT_W       = $clog2(DEB_CYCLES + 1);
    // The level is accepted on the edge whose increment would reach
    // DEB_CYCLES, so the DEB_CYCLES-th differing sample commits it.
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [1:0]       MODE_TOGGLE = 2'b01;

    // -------------------------------------------------------------------------
    // lab1 logic function. Bits above 3 pass straight through; bit 2 is the OR
    // of the already computed bits 1 and 3.
    // -------------------------------------------------------------------------
    function automatic logic [N_SW-1:0] lab1_fn(input logic [N_SW-1:0] s);
        logic [N_SW-1:0] f;
        f    = s;
        f[0] = ~s[0];
        f[1] = s[1] & ~s[2];
        f[3] = s[2] & s[3];
        f[2] = f[1] | f[3];
        return f;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [N_SW-1:0]            meta_q, meta_d;
    logic [N_SW-1:0]            sy_q, sy_d;
    logic [N_SW-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [N_SW-1:0]            sw_db_q, sw_db_d;
    logic [N_SW-1:0]            tg_q, tg_d;
    logic [N_SW-1:0]            led_q, led_d;
    logic                       chg_q, chg_d;

    // -------------------------------------------------------------------------
    // Stage 1: two-flop synchroniser
    // -------------------------------------------------------------------------
    always_comb begin
        meta_d = swt;
        sy_d   = meta_q;
    end

    // -------------------------------------------------------------------------
    // Stage 2: debounce, change detect and toggle register
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_d   = cnt_q;
        sw_db_d = sw_db_q;
        for (int i = 0; i < N_SW; i++) begin
            if (sy_q[i] == sw_db_q[i]) begin
                // Any sample agreeing with the accepted level restarts the window.
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                sw_db_d[i] = sy_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    always_comb begin
        chg_d = |(sw_db_d ^ sw_db_q);
        // Each bit flips on its own debounced rising edge, independent of mode,
        // so the toggle state survives mode changes.
        tg_d  = tg_q ^ (sw_db_d & ~sw_db_q);
    end

`ifdef LED_BLINK_EN
    // -------------------------------------------------------------------------
    // Free-running blink generator: blink flips every BLINK_DIV cycles.
    // -------------------------------------------------------------------------
    localparam int               BLK_W      = $clog2(BLINK_DIV + 1);
    localparam logic [BLK_W-1:0] BLK_LAST   = BLK_W'(BLINK_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_ONE    = BLK_W'(1);
    localparam logic [1:0]       MODE_BLINK = 2'b10;

    logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
    logic             blink_q, blink_d;

    always_comb begin
        blk_cnt_d = blk_cnt_q + BLK_ONE;
        blink_d   = blink_q;
        if (blk_cnt_q == BLK_LAST) begin
            blk_cnt_d = '0;
            blink_d   = ~blink_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blk_cnt_q <= '0;
            blink_q   <= 1'b0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
            blink_q   <= blink_d;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Stage 3: LED source select. Works from registered sw_db/tg, so the LEDs
    // follow the debounced vector one edge later, and a mode change shows up
    // on the very next edge.
    // -------------------------------------------------------------------------
    always_comb begin
        led_d = lab1_fn(sw_db_q);
        if (mode == MODE_TOGGLE) begin
            led_d = tg_q;
        end
`ifdef LED_BLINK_EN
        else if (mode == MODE_BLINK) begin
            led_d = sw_db_q & {N_SW{blink_q}};
        end
`endif
    end

    // -------------------------------------------------------------------------
    // Register bank
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q  <= '0;
            sy_q    <= '0;
            cnt_q   <= '0;
            sw_db_q <= '0;
            tg_q    <= '0;
            led_q   <= '0;
            chg_q   <= 1'b0;
        end else begin
            meta_q  <= meta_d;
            sy_q    <= sy_d;
            cnt_q   <= cnt_d;
            sw_db_q <= sw_db_d;
            tg_q    <= tg_d;
            led_q   <= led_d;
            chg_q   <= chg_d;
        end
    end

    assign led   = led_q;
    assign sw_db = sw_db_q;
    assign chg   = chg_q;

endmodule

// File: tb/tb_swt_led_ctrl.sv
`timescale 1ns/1ps
module tb_swt_led_ctrl;

    localparam int N_SW = 8;
    localparam int DEB  = 4;
    localparam int BDIV = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] swt;
    logic [1:0] mode;
    logic [7:0] led;
    logic [7:0] sw_db;
    logic       chg;

    swt_led_ctrl #(
        .N_SW      (N_SW),
        .DEB_CYCLES(DEB),
        .BLINK_DIV (BDIV)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .swt  (swt),
        .mode (mode),
        .led  (led),
        .sw_db(sw_db),
        .chg  (chg)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [7:0] swt;
        logic [1:0] mode;
        logic [7:0] exp_db;
        logic [7:0] exp_led;
    } vec_t;
    vec_t vecs[$];

    // scratch state for the multi-cycle sequences
    logic       chg_seen;
    logic [7:0] db_or;
    logic [7:0] prev;
    int         run_len, trans, bad_len, bad_val;

    task automatic push(input string nm, input logic [7:0] e);
        sb_t r;
        r.name = nm;
        r.exp  = e;
        sb_q.push_back(r);
    endtask

    task automatic pop_cmp(input logic [7:0] act);
        sb_t r;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_underflow actual=%02h", act);
        end else begin
            r = sb_q.pop_front();
            if (act !== r.exp) begin
                n_bad++;
                $display("FAIL %s actual=%02h expected=%02h", r.name, act, r.exp);
            end
        end
    endtask

    // inputs change and outputs are sampled 1ns after the rising edge
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic vec_t mk(input logic [7:0] s, input logic [1:0] m,
                                input logic [7:0] d, input logic [7:0] l);
        vec_t v;
        v.swt = s; v.mode = m; v.exp_db = d; v.exp_led = l;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back(mk(8'h02, 2'b00, 8'h02, 8'h07));
        vecs.push_back(mk(8'h06, 2'b00, 8'h06, 8'h01));
        vecs.push_back(mk(8'h0F, 2'b00, 8'h0F, 8'h0C));
        vecs.push_back(mk(8'hF0, 2'b00, 8'hF0, 8'hF1));
        vecs.push_back(mk(8'hA5, 2'b00, 8'hA5, 8'hA0));
        vecs.push_back(mk(8'h5A, 2'b00, 8'h5A, 8'h57));
        vecs.push_back(mk(8'hFF, 2'b00, 8'hFF, 8'hFC));
        vecs.push_back(mk(8'h0C, 2'b11, 8'h0C, 8'h0D));
`ifndef LED_BLINK_EN
        vecs.push_back(mk(8'h81, 2'b10, 8'h81, 8'h80));
`endif
        vecs.push_back(mk(8'h0C, 2'b00, 8'h0C, 8'h0D));

        // ---- reset state with all switches high
        reset = 1'b1; swt = 8'hFF; mode = 2'b00;
        push("rst_led", 8'h00); push("rst_sw_db", 8'h00); push("rst_chg", 8'h00);
        step(3);
        pop_cmp(led); pop_cmp(sw_db); pop_cmp({7'd0, chg});

        reset = 1'b0; swt = 8'h00;
        push("idle_led", 8'h01);
        step(1);
        pop_cmp(led);

        // ---- debounce latency 00 -> 0C
        swt = 8'h0C;
        push("deb_early_db", 8'h00); push("deb_early_chg", 8'h00);
        push("deb_db", 8'h0C); push("deb_chg", 8'h01); push("deb_led_hold", 8'h01);
        push("deb_led", 8'h0D); push("deb_chg_end", 8'h00);
        step(5);
        pop_cmp(sw_db); pop_cmp({7'd0, chg});
        step(1);
        pop_cmp(sw_db); pop_cmp({7'd0, chg}); pop_cmp(led);
        step(1);
        pop_cmp(led); pop_cmp({7'd0, chg});

        // ---- glitch rejection: 01/00 every 2 cycles
        swt = 8'h00;
        push("settle0_db", 8'h00);
        step(8);
        pop_cmp(sw_db);
        chg_seen = 1'b0; db_or = 8'h00;
        push("glitch_chg", 8'h00); push("glitch_db", 8'h00);
        for (int k = 0; k < 40; k++) begin
            swt = ((k / 2) % 2 == 0) ? 8'h01 : 8'h00;
            step(1);
            chg_seen |= chg; db_or |= sw_db;
        end
        swt = 8'h00;
        step(4);
        chg_seen |= chg; db_or |= sw_db;
        pop_cmp({7'd0, chg_seen}); pop_cmp(db_or);

        // ---- boundary: DEB-1 sample pulse rejected, DEB sample pulse accepted
        db_or = 8'h00;
        push("pulse3_db", 8'h00);
        swt = 8'h01; step(3);
        swt = 8'h00;
        for (int k = 0; k < 10; k++) begin step(1); db_or |= sw_db; end
        pop_cmp(db_or);
        db_or = 8'h00;
        push("pulse4_db", 8'h01);
        swt = 8'h01; step(4);
        swt = 8'h00;
        for (int k = 0; k < 4; k++) begin step(1); db_or |= sw_db; end
        pop_cmp(db_or);
        step(10);

        // ---- logic function table
        foreach (vecs[i]) begin
            swt = vecs[i].swt; mode = vecs[i].mode;
            push($sformatf("tbl%0d_db", i), vecs[i].exp_db);
            push($sformatf("tbl%0d_led", i), vecs[i].exp_led);
            step(8);
            pop_cmp(sw_db); pop_cmp(led);
        end

        // ---- reset mid-debounce
        swt = 8'hFF; mode = 2'b00;
        step(3);
        reset = 1'b1;
        push("midrst_db", 8'h00);
        #1;
        pop_cmp(sw_db);
        step(1);
        reset = 1'b0;
        push("midrst_db_early", 8'h00); push("midrst_db", 8'hFF); push("midrst_chg", 8'h01);
        step(5);
        pop_cmp(sw_db);
        step(1);
        pop_cmp(sw_db); pop_cmp({7'd0, chg});

        // ---- toggle mode
        swt = 8'h00; reset = 1'b1;
        step(2);
        reset = 1'b0; mode = 2'b01;
        push("tg_idle_led", 8'h00);
        step(2);
        pop_cmp(led);

        swt = 8'h20;
        push("tg_p1_chg_early", 8'h00); push("tg_p1_chg", 8'h01);
        push("tg_p1_led", 8'h20); push("tg_p1_chg_end", 8'h00);
        step(5); pop_cmp({7'd0, chg});
        step(1); pop_cmp({7'd0, chg});
        step(1); pop_cmp(led); pop_cmp({7'd0, chg});

        swt = 8'h00;
        push("tg_r_chg", 8'h01); push("tg_r_led", 8'h20);
        step(6); pop_cmp({7'd0, chg});
        step(1); pop_cmp(led);

        swt = 8'h20;
        push("tg_p2_chg", 8'h01); push("tg_p2_led", 8'h00);
        step(6); pop_cmp({7'd0, chg});
        step(1); pop_cmp(led);

        // simultaneous rising edges on bits 0 and 1
        swt = 8'h23;
        push("tg_multi_led", 8'h03);
        step(7); pop_cmp(led);

        // mode change takes effect on the next edge; toggle state persists
        mode = 2'b00;
        push("mode_to_logic_led", 8'h26);
        step(1); pop_cmp(led);
        mode = 2'b01;
        push("mode_to_tg_led", 8'h03);
        step(1); pop_cmp(led);

        // ---- mode 10
        swt = 8'h81; mode = 2'b10;
        step(8);
        bad_val = 0; bad_len = 0; trans = 0; run_len = 0;
        prev = led;
`ifdef LED_BLINK_EN
        push("blink_vals", 8'h00); push("blink_period", 8'h00); push("blink_active", 8'h01);
        for (int k = 0; k < 40; k++) begin
            step(1);
            if (led !== 8'h81 && led !== 8'h00) bad_val++;
            if (led !== prev) begin
                if (trans > 0 && run_len != BDIV) bad_len++;
                trans++;
                run_len = 1;
            end else begin
                run_len++;
            end
            prev = led;
        end
        pop_cmp(8'(bad_val)); pop_cmp(8'(bad_len)); pop_cmp({7'd0, trans >= 4});
`else
        push("mode10_led", 8'h00);
        for (int k = 0; k < 32; k++) begin
            step(1);
            if (led !== 8'h80) bad_val++;
        end
        pop_cmp(8'(bad_val));
`endif

        // ---- every expectation consumed
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
